// File: rtl/sr_input_reader.sv
// -----------------------------------------------------------------------------
// sr_input_reader
//
// Purpose:
//   Reads a daisy-chained 74HC165-class parallel-in/serial-out shift register
//   chain carrying the game-box buttons and switches. It drives the
//   parallel-load and shift-clock pins and samples the serial line through a
//   two-flop synchronizer. It assembles NBITS-wide frames MSB-first and
//   presents each accepted frame as a registered word with one-cycle strobes.
//
// Parameters:
//   NBITS - number of bits in the chain (multiple of 8, 8..64)
//   DIV   - tick period minus 1, in CLK1_50 cycles (DIV >= 3)
//   GAP   - idle ticks between frames (>= 1)
//
// Ports:
//   CLK1_50  in   system clock (50 MHz)
//   CLR      in   synchronous active-low reset
//   SR_QH    in   serial data from the last register of the chain (async)
//   SR_PL_N  out  parallel-load strobe, active low (registered)
//   SR_CLK   out  shift clock to the chain (registered)
//   data     out  last accepted frame, data[NBITS-1] = first bit received
//   valid    out  one-cycle strobe when a frame is accepted
//   changed  out  one-cycle strobe with valid when data differs from before
//   busy     out  high while in LOAD / SHIFT_LO / SHIFT_HI (registered)
//
// Handshake:
//   valid is a pure strobe with no back-pressure. data, valid and changed all
//   update on the same clock edge, so a consumer may capture data whenever
//   valid is high. data holds its value until the next accepted frame or a
//   reset.
//
// Optional feature (macro SR_INPUT_READER_DEBOUNCE_EN):
//   When defined, a frame is accepted only if it equals the previously
//   assembled frame, which is held in a candidate register. The first frame
//   after reset is never accepted. When undefined, every frame is accepted and
//   no candidate register exists.
// -----------------------------------------------------------------------------
module sr_input_reader #(
    parameter int NBITS = 16,
    parameter int DIV   = 499,
    parameter int GAP   = 100
) (
    input  logic             CLK1_50,
    input  logic             CLR,
    input  logic             SR_QH,
    output logic             SR_PL_N,
    output logic             SR_CLK,
    output logic [NBITS-1:0] data,
    output logic             valid,
    output logic             changed,
    output logic             busy
);

    localparam int TW = (DIV > 0) ? $clog2(DIV + 1) : 1;
    localparam int BW = $clog2(NBITS);
    localparam int GW = $clog2(GAP + 1);

    typedef enum logic [2:0] {
        ST_LOAD_WAIT = 3'd0,
        ST_LOAD      = 3'd1,
        ST_SHIFT_LO  = 3'd2,
        ST_SHIFT_HI  = 3'd3,
        ST_ACCEPT    = 3'd4,
        ST_GAP_WAIT  = 3'd5
    } state_t;

    state_t            state_q,    state_d;
    logic [TW-1:0]     tick_cnt_q, tick_cnt_d;
    logic [BW-1:0]     bit_cnt_q,  bit_cnt_d;
    logic [GW-1:0]     gap_cnt_q,  gap_cnt_d;
    logic [NBITS-1:0]  shift_q,    shift_d;
    logic [NBITS-1:0]  data_q,     data_d;
    logic              valid_q,    valid_d;
    logic              changed_q,  changed_d;
    logic              pl_n_q,     pl_n_d;
    logic              sclk_q,     sclk_d;
    logic              busy_q,     busy_d;
    logic              qh_meta_q,  qh_meta_d;
    logic              qh_sync_q,  qh_sync_d;
`ifdef SR_INPUT_READER_DEBOUNCE_EN
    logic [NBITS-1:0]  cand_q,     cand_d;
    // Cleared by reset so that the first frame is never accepted, even if
    // it happens to equal the cleared candidate value.
    logic              cand_ok_q,  cand_ok_d;
`endif

    logic tick;
    logic accept_frame;

    assign tick = (tick_cnt_q == TW'(DIV));

    // -------------------------------------------------------------------------
    // State register and all other flops
    // -------------------------------------------------------------------------
    always_ff @(posedge CLK1_50) begin
        if (!CLR) begin
            state_q    <= ST_LOAD_WAIT;
            tick_cnt_q <= '0;
            bit_cnt_q  <= '0;
            gap_cnt_q  <= '0;
            shift_q    <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            changed_q  <= 1'b0;
            pl_n_q     <= 1'b1;
            sclk_q     <= 1'b0;
            busy_q     <= 1'b0;
            qh_meta_q  <= 1'b0;
            qh_sync_q  <= 1'b0;
`ifdef SR_INPUT_READER_DEBOUNCE_EN
            cand_q     <= '0;
            cand_ok_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            shift_q    <= shift_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            changed_q  <= changed_d;
            pl_n_q     <= pl_n_d;
            sclk_q     <= sclk_d;
            busy_q     <= busy_d;
            qh_meta_q  <= qh_meta_d;
            qh_sync_q  <= qh_sync_d;
`ifdef SR_INPUT_READER_DEBOUNCE_EN
            cand_q     <= cand_d;
            cand_ok_q  <= cand_ok_d;
`endif
        end
    end

    // -------------------------------------------------------------------------
    // Acceptance decision for the frame sitting in shift_q during ACCEPT
    // -------------------------------------------------------------------------
`ifdef SR_INPUT_READER_DEBOUNCE_EN
    assign accept_frame = cand_ok_q && (shift_q == cand_q);
`else
    assign accept_frame = 1'b1;
`endif

    // -------------------------------------------------------------------------
    // Next-state and datapath logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        gap_cnt_d = gap_cnt_q;
        shift_d   = shift_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        changed_d = 1'b0;
        qh_meta_d = SR_QH;
        qh_sync_d = qh_meta_q;
`ifdef SR_INPUT_READER_DEBOUNCE_EN
        cand_d    = cand_q;
        cand_ok_d = cand_ok_q;
`endif

        // The tick counter holds during the single ACCEPT cycle, so every
        // frame is exactly one clock longer than a whole number of ticks.
        if (state_q == ST_ACCEPT) begin
            tick_cnt_d = tick_cnt_q;
        end else if (tick) begin
            tick_cnt_d = '0;
        end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
        end

        case (state_q)
            ST_LOAD_WAIT: begin
                if (tick) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (tick) begin
                    state_d   = ST_SHIFT_LO;
                    bit_cnt_d = '0;
                end
            end
            ST_SHIFT_LO: begin
                // Sample while SR_CLK is low, then raise SR_CLK to advance
                // the chain. The last bit goes straight to ACCEPT, so the
                // chain sees only NBITS-1 rising edges per frame.
                if (tick) begin
                    shift_d   = {shift_q[NBITS-2:0], qh_sync_q};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == BW'(NBITS - 1)) begin
                        state_d = ST_ACCEPT;
                    end else begin
                        state_d = ST_SHIFT_HI;
                    end
                end
            end
            ST_SHIFT_HI: begin
                if (tick) begin
                    state_d = ST_SHIFT_LO;
                end
            end
            ST_ACCEPT: begin
                state_d   = ST_GAP_WAIT;
                gap_cnt_d = '0;
                if (accept_frame) begin
                    data_d    = shift_q;
                    valid_d   = 1'b1;
                    changed_d = (shift_q != data_q);
                end
`ifdef SR_INPUT_READER_DEBOUNCE_EN
                cand_d    = shift_q;
                cand_ok_d = 1'b1;
`endif
            end
            ST_GAP_WAIT: begin
                // GAP ticks are counted, and the tick after that starts the
                // next LOAD.
                if (tick) begin
                    if (gap_cnt_q == GW'(GAP)) begin
                        state_d = ST_LOAD;
                    end else begin
                        gap_cnt_d = gap_cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_LOAD_WAIT;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Registered pin outputs are decoded from the next state, so they change
    // on the same edge as the state. SR_CLK and SR_PL_N come from disjoint
    // states and can never be active together.
    // -------------------------------------------------------------------------
    always_comb begin
        pl_n_d = (state_d != ST_LOAD);
        sclk_d = (state_d == ST_SHIFT_HI);
        busy_d = (state_d == ST_LOAD) ||
                 (state_d == ST_SHIFT_LO) ||
                 (state_d == ST_SHIFT_HI);
    end

    assign SR_PL_N = pl_n_q;
    assign SR_CLK  = sclk_q;
    assign busy    = busy_q;
    assign data    = data_q;
    assign valid   = valid_q;
    assign changed = changed_q;

endmodule
